pi_cmd_frontend: RTL and testbench
==================================

Name: pi_cmd_frontend

Overview:
Pi-side command front end for the PiStorm SXB CPLD. It synchronises the PI_RD/PI_WR GPIO strobes into the 68K clock domain and decodes the 2-bit register address. It assembles address, data and control words into one transaction request for the downstream 68K bus-cycle state machine, then returns read data and status to the Pi. It replaces the strobe-level latch logic with a clocked request/acknowledge interface.

Parameters:
SYNC_STAGES, 2, flip-flop stages on PI_RD/PI_WR/PI_A/PI_D before edge detection (min 2)
FWREV, 11'h001, firmware revision returned in the status word
TIMEOUT_CYCLES, 1023, M68K_CLK cycles before a stalled transaction is aborted (optional feature only)

Ports:
M68K_CLK  in  1  single clock; all logic on posedge
M68K_RESET_n  in  1  asynchronous active-low reset
PI_A  in  2  register select: 0 DATA, 1 ADDR_LO, 2 ADDR_HI, 3 STATUS
PI_RD  in  1  Pi read strobe, active high
PI_WR  in  1  Pi write strobe, active high
PI_D_IN  in  16  Pi write data
PI_D_OUT  out  16  Pi read data
PI_D_OE  out  1  drive enable for PI_D pads
IPL  in  3  active-high interrupt level, already synchronised
TXN_REQ  out  1  transaction request to bus state machine
TXN_ACK  in  1  one-cycle pulse: bus cycle finished (S6)
TXN_RDATA  in  16  read data, valid with TXN_ACK
TXN_ADDR  out  24  A23..A0
TXN_WDATA  out  16  write data
TXN_RW  out  1  1 read, 0 write
TXN_UDS_n  out  1  upper strobe
TXN_LDS_n  out  1  lower strobe
TXN_FC  out  3  function code
PI_TXN_IN_PROGRESS  out  1  busy flag to Pi GPIO0
STATUS_WE  out  1  one-cycle pulse on STATUS write
STATUS_D  out  16  value written to STATUS, held until next write

Behaviour:
- Reset values: all outputs 0, except TXN_RW=1, TXN_UDS_n=1, TXN_LDS_n=1, TXN_FC=3'b110, and PI_D_OE=0.
- Strobe handling: PI_RD, PI_WR, PI_A and PI_D_IN pass through SYNC_STAGES flops. One more register gives edge detect. The Pi holds A/D stable ≥ SYNC_STAGES+2 clocks around each strobe.
- Write commit: on the synced PI_WR rising edge, the synced PI_A selects the action:
  - DATA: TXN_WDATA <= D.
  - ADDR_LO: TXN_ADDR[15:0] <= D.
  - ADDR_HI: TXN_ADDR[23:16] <= D[7:0]; TXN_RW <= D[9]; TXN_FC <= D[15:13]. If D[8]=1 (byte), UDS_n = A0 and LDS_n = ~A0; otherwise both strobes are 0. The transaction then launches.
  - STATUS: STATUS_D <= D; STATUS_WE pulses.
- FSM states:
  - IDLE -> REQ on ADDR_HI commit. TXN_REQ and PI_TXN_IN_PROGRESS go 1 in the same cycle.
  - REQ -> IDLE on TXN_ACK. TXN_REQ and PI_TXN_IN_PROGRESS drop the next cycle. If TXN_RW=1, rdata_q <= TXN_RDATA.
- Writes while in REQ: DATA, ADDR_LO and ADDR_HI writes are ignored, and sticky ovr_err is set. STATUS writes are always accepted.
- TXN_ACK while in IDLE is ignored.
- Read path: PI_D_OE=1 from the synced PI_RD high cycle until the synced PI_RD low. PI_D_OUT is registered from the synced PI_A:
  - DATA: rdata_q.
  - ADDR_LO: TXN_ADDR[15:0].
  - ADDR_HI: {TXN_FC, 3'b0, TXN_RW, byte, TXN_ADDR[23:16]}.
  - STATUS: {IPL, FWREV, PI_TXN_IN_PROGRESS, ovr_err}.
- ovr_err clears on a STATUS read, unless it is set in the same cycle; set wins.
- Reset mid-transaction: immediate return to IDLE; rdata_q cleared.
- Simultaneous synced RD and WR edges: the write is processed, and the read output still updates.

Optional Feature:
TXN_TIMEOUT_EN
- Defined: a 10-bit counter runs in REQ and clears on entry. When it reaches TIMEOUT_CYCLES with no TXN_ACK:
  - the FSM returns to IDLE;
  - rdata_q <= 16'hFFFF;
  - sticky tmo_err is set and reported in STATUS bit 0, ORed with ovr_err;
  - tmo_err clears on a STATUS read.
- Undefined: no counter; REQ waits for TXN_ACK indefinitely.

Test Plan:
- Word read: write ADDR_LO=16'h8000, ADDR_HI=16'h02FF; ACK with RDATA=16'hBEEF -> TXN_ADDR=24'hFF8000, RW=1, UDS_n=LDS_n=0, FC=0. DATA read returns 16'hBEEF; busy 1 -> 0 one cycle after ACK.
- Byte write: DATA=16'h00A5, ADDR_LO=16'h0001, ADDR_HI=16'hA100 -> RW=0, UDS_n=1, LDS_n=0, FC=3'b101, WDATA=16'h00A5.
- Overrun: ADDR_HI write while REQ -> TXN_ADDR unchanged; STATUS bit 0 reads 1, then reads 0 on the next STATUS read.
- Status: IPL=3'b110 -> STATUS read = {3'b110, FWREV, busy, err}. STATUS write 16'h0002 -> STATUS_WE pulses once and STATUS_D=16'h0002.
- Reset mid-transaction: assert M68K_RESET_n low while in REQ -> TXN_REQ=0, PI_TXN_IN_PROGRESS=0, outputs at reset values within the same cycle.
- With TXN_TIMEOUT_EN and TIMEOUT_CYCLES=15, no ACK -> IDLE after 15 cycles; DATA reads 16'hFFFF; STATUS bit 0 = 1.

Source files
------------

// File: rtl/pi_cmd_frontend.sv
// rtl/pi_cmd_frontend.sv - Pi-side command front end: strobe sync, register decode, bus transaction request.
// Optional build macro: TXN_TIMEOUT_EN (aborts stalled transactions after TIMEOUT_CYCLES).
module pi_cmd_frontend #(
    parameter int          SYNC_STAGES    = 2,
    parameter logic [10:0] FWREV          = 11'h001,
    parameter int          TIMEOUT_CYCLES = 1023
) (
    input  logic        M68K_CLK,
    input  logic        M68K_RESET_n,
    input  logic [1:0]  PI_A,
    input  logic        PI_RD,
    input  logic        PI_WR,
    input  logic [15:0] PI_D_IN,
    output logic [15:0] PI_D_OUT,
    output logic        PI_D_OE,
    input  logic [2:0]  IPL,
    output logic        TXN_REQ,
    input  logic        TXN_ACK,
    input  logic [15:0] TXN_RDATA,
    output logic [23:0] TXN_ADDR,
    output logic [15:0] TXN_WDATA,
    output logic        TXN_RW,
    output logic        TXN_UDS_n,
    output logic        TXN_LDS_n,
    output logic [2:0]  TXN_FC,
    output logic        PI_TXN_IN_PROGRESS,
    output logic        STATUS_WE,
    output logic [15:0] STATUS_D
);

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_ADDR_LO = 2'd1;
    localparam logic [1:0] REG_ADDR_HI = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] rd_sync;
    logic [SYNC_STAGES-1:0] wr_sync;
    logic [1:0]             a_sync [SYNC_STAGES];
    logic [15:0]            d_sync [SYNC_STAGES];
    logic                   rd_d, wr_d;

    logic        rd_s, wr_s, rd_rise, wr_rise;
    logic [1:0]  a_s;
    logic [15:0] d_s;
    logic        accept, launch, ack_hit, tmo_hit, ovr_set, stat_rd;
    logic        ovr_err, err_bit, byte_q;
    logic [15:0] rdata_q;
    logic [15:0] rd_mux;

    // A/D travel through the same depth as the strobes so they line up at the edge detector
    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            rd_sync <= '0;
            wr_sync <= '0;
            rd_d    <= 1'b0;
            wr_d    <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                a_sync[i] <= 2'd0;
                d_sync[i] <= 16'd0;
            end
        end else begin
            rd_sync   <= {rd_sync[SYNC_STAGES-2:0], PI_RD};
            wr_sync   <= {wr_sync[SYNC_STAGES-2:0], PI_WR};
            a_sync[0] <= PI_A;
            d_sync[0] <= PI_D_IN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                a_sync[i] <= a_sync[i-1];
                d_sync[i] <= d_sync[i-1];
            end
            rd_d <= rd_sync[SYNC_STAGES-1];
            wr_d <= wr_sync[SYNC_STAGES-1];
        end
    end

    assign rd_s    = rd_sync[SYNC_STAGES-1];
    assign wr_s    = wr_sync[SYNC_STAGES-1];
    assign a_s     = a_sync[SYNC_STAGES-1];
    assign d_s     = d_sync[SYNC_STAGES-1];
    assign rd_rise = rd_s & ~rd_d;
    assign wr_rise = wr_s & ~wr_d;

    assign accept  = wr_rise && (state_q == IDLE);
    assign launch  = accept && (a_s == REG_ADDR_HI);
    assign ack_hit = (state_q == REQ) && TXN_ACK;
    assign ovr_set = wr_rise && (state_q == REQ) && (a_s != REG_STATUS);
    assign stat_rd = rd_rise && (a_s == REG_STATUS);

`ifdef TXN_TIMEOUT_EN
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

    logic [9:0] tmo_cnt;
    logic       tmo_err;

    // Counter is held at zero in IDLE, so it restarts on every REQ entry
    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            tmo_cnt <= 10'd0;
            tmo_err <= 1'b0;
        end else begin
            tmo_cnt <= (state_q == REQ) ? tmo_cnt + 10'd1 : 10'd0;
            tmo_err <= tmo_hit | (tmo_err & ~stat_rd);
        end
    end

    assign tmo_hit = (state_q == REQ) && !TXN_ACK && (tmo_cnt == TMO_LAST);
    assign err_bit = ovr_err | tmo_err;
`else
    logic unused_tmo;

    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
    assign err_bit    = ovr_err;
`endif

    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        TXN_REQ            = 1'b0;
        PI_TXN_IN_PROGRESS = 1'b0;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                TXN_REQ            = 1'b1;
                PI_TXN_IN_PROGRESS = 1'b1;
                if (TXN_ACK || tmo_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Transaction request words; only STATUS is writable while a bus cycle is outstanding
    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            TXN_ADDR  <= 24'd0;
            TXN_WDATA <= 16'd0;
            TXN_RW    <= 1'b1;
            TXN_UDS_n <= 1'b1;
            TXN_LDS_n <= 1'b1;
            TXN_FC    <= 3'b110;
            byte_q    <= 1'b0;
            STATUS_D  <= 16'd0;
            STATUS_WE <= 1'b0;
        end else begin
            STATUS_WE <= 1'b0;
            if (wr_rise && (a_s == REG_STATUS)) begin
                STATUS_D  <= d_s;
                STATUS_WE <= 1'b1;
            end
            if (accept) begin
                case (a_s)
                    REG_DATA:    TXN_WDATA <= d_s;
                    REG_ADDR_LO: TXN_ADDR[15:0] <= d_s;
                    REG_ADDR_HI: begin
                        TXN_ADDR[23:16] <= d_s[7:0];
                        TXN_RW          <= d_s[9];
                        TXN_FC          <= d_s[15:13];
                        byte_q          <= d_s[8];
                        TXN_UDS_n       <= d_s[8] & TXN_ADDR[0];
                        TXN_LDS_n       <= d_s[8] & ~TXN_ADDR[0];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Set wins over the clear-on-STATUS-read
    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            ovr_err <= 1'b0;
            rdata_q <= 16'd0;
        end else begin
            ovr_err <= ovr_set | (ovr_err & ~stat_rd);
            if (ack_hit && TXN_RW) begin
                rdata_q <= TXN_RDATA;
            end else if (tmo_hit) begin
                rdata_q <= 16'hFFFF;
            end
        end
    end

    always_comb begin
        rd_mux = 16'd0;
        case (a_s)
            REG_DATA:    rd_mux = rdata_q;
            REG_ADDR_LO: rd_mux = TXN_ADDR[15:0];
            REG_ADDR_HI: rd_mux = {TXN_FC, 3'b000, TXN_RW, byte_q, TXN_ADDR[23:16]};
            REG_STATUS:  rd_mux = {IPL, FWREV, PI_TXN_IN_PROGRESS, err_bit};
            default:     rd_mux = 16'd0;
        endcase
    end

    // Read word is captured at the strobe edge so a clear-on-read cannot alter it mid-strobe
    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            PI_D_OE  <= 1'b0;
            PI_D_OUT <= 16'd0;
        end else begin
            PI_D_OE <= rd_s;
            if (rd_rise) begin
                PI_D_OUT <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_pi_cmd_frontend.sv
// tb/tb_pi_cmd_frontend.sv - directed self-checking bench for pi_cmd_frontend.
module tb_pi_cmd_frontend;

    logic        M68K_CLK = 1'b0;
    logic        M68K_RESET_n;
    logic [1:0]  PI_A;
    logic        PI_RD;
    logic        PI_WR;
    logic [15:0] PI_D_IN;
    logic [15:0] PI_D_OUT;
    logic        PI_D_OE;
    logic [2:0]  IPL;
    logic        TXN_REQ;
    logic        TXN_ACK;
    logic [15:0] TXN_RDATA;
    logic [23:0] TXN_ADDR;
    logic [15:0] TXN_WDATA;
    logic        TXN_RW;
    logic        TXN_UDS_n;
    logic        TXN_LDS_n;
    logic [2:0]  TXN_FC;
    logic        PI_TXN_IN_PROGRESS;
    logic        STATUS_WE;
    logic [15:0] STATUS_D;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          we_cnt;
    logic [15:0] rd_val;
    logic        rd_oe;

    pi_cmd_frontend #(
        .SYNC_STAGES    (2),
        .FWREV          (11'h001),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .M68K_CLK           (M68K_CLK),
        .M68K_RESET_n       (M68K_RESET_n),
        .PI_A               (PI_A),
        .PI_RD              (PI_RD),
        .PI_WR              (PI_WR),
        .PI_D_IN            (PI_D_IN),
        .PI_D_OUT           (PI_D_OUT),
        .PI_D_OE            (PI_D_OE),
        .IPL                (IPL),
        .TXN_REQ            (TXN_REQ),
        .TXN_ACK            (TXN_ACK),
        .TXN_RDATA          (TXN_RDATA),
        .TXN_ADDR           (TXN_ADDR),
        .TXN_WDATA          (TXN_WDATA),
        .TXN_RW             (TXN_RW),
        .TXN_UDS_n          (TXN_UDS_n),
        .TXN_LDS_n          (TXN_LDS_n),
        .TXN_FC             (TXN_FC),
        .PI_TXN_IN_PROGRESS (PI_TXN_IN_PROGRESS),
        .STATUS_WE          (STATUS_WE),
        .STATUS_D           (STATUS_D)
    );

    always #5 M68K_CLK = ~M68K_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pi_write(input logic [1:0] a, input logic [15:0] d);
        @(negedge M68K_CLK);
        PI_A    = a;
        PI_D_IN = d;
        PI_WR   = 1'b1;
        we_cnt  = 0;
        repeat (6) begin
            @(negedge M68K_CLK);
            we_cnt += int'(STATUS_WE);
        end
        PI_WR = 1'b0;
        repeat (6) begin
            @(negedge M68K_CLK);
            we_cnt += int'(STATUS_WE);
        end
    endtask

    task automatic pi_read(input logic [1:0] a);
        @(negedge M68K_CLK);
        PI_A  = a;
        PI_RD = 1'b1;
        repeat (6) @(negedge M68K_CLK);
        rd_val = PI_D_OUT;
        rd_oe  = PI_D_OE;
        PI_RD  = 1'b0;
        repeat (6) @(negedge M68K_CLK);
    endtask

    task automatic ack_pulse(input logic [15:0] rdata);
        @(negedge M68K_CLK);
        TXN_RDATA = rdata;
        TXN_ACK   = 1'b1;
        @(negedge M68K_CLK);
        TXN_ACK   = 1'b0;
    endtask

    initial begin
        M68K_RESET_n = 1'b0;
        PI_A = 2'd0; PI_RD = 1'b0; PI_WR = 1'b0; PI_D_IN = 16'd0;
        IPL = 3'b000; TXN_ACK = 1'b0; TXN_RDATA = 16'd0;
        repeat (3) @(negedge M68K_CLK);

        chk("rst_req",   {31'd0, TXN_REQ}, 0);
        chk("rst_busy",  {31'd0, PI_TXN_IN_PROGRESS}, 0);
        chk("rst_rw",    {31'd0, TXN_RW}, 1);
        chk("rst_uds",   {31'd0, TXN_UDS_n}, 1);
        chk("rst_lds",   {31'd0, TXN_LDS_n}, 1);
        chk("rst_fc",    {29'd0, TXN_FC}, 3'b110);
        chk("rst_addr",  {8'd0, TXN_ADDR}, 0);
        chk("rst_oe",    {31'd0, PI_D_OE}, 0);
        chk("rst_dout",  {16'd0, PI_D_OUT}, 0);
        chk("rst_we",    {31'd0, STATUS_WE}, 0);
        chk("rst_sd",    {16'd0, STATUS_D}, 0);

        M68K_RESET_n = 1'b1;
        repeat (2) @(negedge M68K_CLK);

        // Word read at 0xFF8000
        pi_write(2'd1, 16'h8000);
        chk("w_idle_req", {31'd0, TXN_REQ}, 0);
        pi_write(2'd2, 16'h02FF);
        chk("w_req",   {31'd0, TXN_REQ}, 1);
        chk("w_busy",  {31'd0, PI_TXN_IN_PROGRESS}, 1);
        chk("w_addr",  {8'd0, TXN_ADDR}, 24'hFF8000);
        chk("w_rw",    {31'd0, TXN_RW}, 1);
        chk("w_uds",   {31'd0, TXN_UDS_n}, 0);
        chk("w_lds",   {31'd0, TXN_LDS_n}, 0);
        chk("w_fc",    {29'd0, TXN_FC}, 0);
        ack_pulse(16'hBEEF);
        chk("w_req_drop",  {31'd0, TXN_REQ}, 0);
        chk("w_busy_drop", {31'd0, PI_TXN_IN_PROGRESS}, 0);
        pi_read(2'd0);
        chk("w_rdata", {16'd0, rd_val}, 16'hBEEF);
        chk("w_oe",    {31'd0, rd_oe}, 1);
        chk("w_oe_off", {31'd0, PI_D_OE}, 0);
        pi_read(2'd2);
        chk("w_rd_hi", {16'd0, rd_val}, 16'h02FF);
        pi_read(2'd1);
        chk("w_rd_lo", {16'd0, rd_val}, 16'h8000);

        // Byte write of 0xA5 to odd address 0x000001
        pi_write(2'd0, 16'h00A5);
        chk("b_data_we", we_cnt, 0);
        pi_write(2'd1, 16'h0001);
        pi_write(2'd2, 16'hA100);
        chk("b_req",   {31'd0, TXN_REQ}, 1);
        chk("b_rw",    {31'd0, TXN_RW}, 0);
        chk("b_uds",   {31'd0, TXN_UDS_n}, 1);
        chk("b_lds",   {31'd0, TXN_LDS_n}, 0);
        chk("b_fc",    {29'd0, TXN_FC}, 3'b101);
        chk("b_wdata", {16'd0, TXN_WDATA}, 16'h00A5);
        chk("b_addr",  {8'd0, TXN_ADDR}, 24'h000001);

        // Overrun: ADDR_HI write while still in REQ
        IPL = 3'b110;
        pi_write(2'd2, 16'h02FF);
        chk("o_addr", {8'd0, TXN_ADDR}, 24'h000001);
        chk("o_rw",   {31'd0, TXN_RW}, 0);
        pi_read(2'd3);
        chk("o_stat1", {16'd0, rd_val}, 16'hC007);
        pi_read(2'd3);
        chk("o_stat2", {16'd0, rd_val}, 16'hC006);
        ack_pulse(16'h1234);
        chk("o_req_drop", {31'd0, TXN_REQ}, 0);
        pi_read(2'd0);
        chk("o_rdata_kept", {16'd0, rd_val}, 16'hBEEF);
        pi_read(2'd3);
        chk("o_stat3", {16'd0, rd_val}, 16'hC004);

        // STATUS write
        pi_write(2'd3, 16'h0002);
        chk("s_we_cnt", we_cnt, 1);
        chk("s_d",      {16'd0, STATUS_D}, 16'h0002);
        chk("s_we_low", {31'd0, STATUS_WE}, 0);

        // ACK while idle must not capture data
        ack_pulse(16'h1111);
        chk("i_req", {31'd0, TXN_REQ}, 0);
        pi_read(2'd0);
        chk("i_rdata", {16'd0, rd_val}, 16'hBEEF);

        // Simultaneous RD and WR on ADDR_LO
        @(negedge M68K_CLK);
        PI_A = 2'd1; PI_D_IN = 16'h1234; PI_RD = 1'b1; PI_WR = 1'b1;
        repeat (6) @(negedge M68K_CLK);
        chk("rw_dout", {16'd0, PI_D_OUT}, 16'h0001);
        chk("rw_oe",   {31'd0, PI_D_OE}, 1);
        PI_RD = 1'b0; PI_WR = 1'b0;
        repeat (6) @(negedge M68K_CLK);
        chk("rw_addr", {8'd0, TXN_ADDR}, 24'h001234);

        // Reset in the middle of a transaction
        pi_write(2'd2, 16'h0200);
        chk("r_req", {31'd0, TXN_REQ}, 1);
        @(negedge M68K_CLK);
        M68K_RESET_n = 1'b0;
        #1;
        chk("r_req0",  {31'd0, TXN_REQ}, 0);
        chk("r_busy0", {31'd0, PI_TXN_IN_PROGRESS}, 0);
        chk("r_fc",    {29'd0, TXN_FC}, 3'b110);
        chk("r_addr",  {8'd0, TXN_ADDR}, 0);
        chk("r_uds",   {31'd0, TXN_UDS_n}, 1);
        repeat (2) @(negedge M68K_CLK);
        M68K_RESET_n = 1'b1;
        repeat (2) @(negedge M68K_CLK);
        pi_read(2'd0);
        chk("r_rdata", {16'd0, rd_val}, 0);

`ifdef TXN_TIMEOUT_EN
        pi_write(2'd2, 16'h0200);
        chk("t_req", {31'd0, TXN_REQ}, 1);
        repeat (20) @(negedge M68K_CLK);
        chk("t_idle", {31'd0, TXN_REQ}, 0);
        pi_read(2'd0);
        chk("t_rdata", {16'd0, rd_val}, 16'hFFFF);
        pi_read(2'd3);
        chk("t_err", {31'd0, rd_val[0]}, 1);
        pi_read(2'd3);
        chk("t_err_clr", {31'd0, rd_val[0]}, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
